neighbor_req_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of the S-Neighbor SRAM

---
 rtl/neighbor_req_arbiter_if.sv | 28 ++
 rtl/neighbor_req_arbiter.sv | 94 +++++++++
 tb/tb_neighbor_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_req_arbiter_if.sv
// Request/write bundle between the requesting PEs, the arbiter and the neighbor FIFO.
// The master side drives requests, completions and backpressure; the arbiter is the slave.
interface neighbor_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_done;
  logic                      wfull;
  logic                      wdata_valid;
  logic [ADDR_W-1:0]         wdata_addr;
  logic [TAG_W-1:0]          wdata_tag;
  logic                      idle;
  logic                      err_underflow;

  modport master (
    output req_valid, req_addr, resp_done, wfull,
    input  req_ready, wdata_valid, wdata_addr, wdata_tag, idle, err_underflow
  );

  modport slave (
    input  req_valid, req_addr, resp_done, wfull,
    output req_ready, wdata_valid, wdata_addr, wdata_tag, idle, err_underflow
  );
endinterface

// File: rtl/neighbor_req_arbiter.sv
// Round-robin arbiter feeding the single neighbor-FIFO write port from NUM_REQ PEs,
// with one holding register per PE and a per-PE outstanding-request limit.
module neighbor_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int TAG_W   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic reset,
  neighbor_req_arbiter_if.slave bus
);
  localparam int CW = TAG_W + 1;

  logic [NUM_REQ-1:0] hold_valid_reg;
  logic [ADDR_W-1:0]  hold_addr_reg [NUM_REQ];
  logic [2:0]         out_cnt_reg   [NUM_REQ];
  logic [TAG_W-1:0]   rr_ptr_reg;
  logic               err_underflow_reg;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] cnt_zero;
  logic [NUM_REQ-1:0] underflow_vec;
  logic               grant_valid;
  logic [TAG_W-1:0]   grant_idx;
  logic [CW-1:0]      cand;

  // Scan from the highest offset down so the offset closest to rr_ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + CW'(k);
      if (cand >= CW'(NUM_REQ))
        cand = cand - CW'(NUM_REQ);
      if (!bus.wfull && elig[cand[TAG_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[TAG_W-1:0];
      end
    end
  end

  assign bus.req_ready     = {NUM_REQ{reset}} & ~hold_valid_reg;
  assign bus.wdata_valid   = reset && grant_valid;
  assign bus.wdata_addr    = (reset && grant_valid) ? hold_addr_reg[grant_idx] : '0;
  assign bus.wdata_tag     = (reset && grant_valid) ? grant_idx : '0;
  assign bus.idle          = !reset || (!(|hold_valid_reg) && (&cnt_zero));
  assign bus.err_underflow = err_underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_pe
      assign elig[gi]          = hold_valid_reg[gi] && (out_cnt_reg[gi] < 3'(MAX_OUT));
      assign grant_vec[gi]     = grant_valid && (grant_idx == TAG_W'(gi));
      assign cnt_zero[gi]      = (out_cnt_reg[gi] == 3'd0);
      assign underflow_vec[gi] = bus.resp_done[gi] && cnt_zero[gi] && !grant_vec[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hold_valid_reg[gi] <= 1'b0;
          hold_addr_reg[gi]  <= '0;
          out_cnt_reg[gi]    <= 3'd0;
        end else begin
          // A granted hold had ready low, so it cannot be refilled in the same edge.
          if (grant_vec[gi]) begin
            hold_valid_reg[gi] <= 1'b0;
          end else if (bus.req_valid[gi] && !hold_valid_reg[gi]) begin
            hold_valid_reg[gi] <= 1'b1;
            hold_addr_reg[gi]  <= bus.req_addr[gi*ADDR_W +: ADDR_W];
          end
          case ({grant_vec[gi], bus.resp_done[gi]})
            2'b10:   out_cnt_reg[gi] <= out_cnt_reg[gi] + 3'd1;
            2'b01:   if (!cnt_zero[gi]) out_cnt_reg[gi] <= out_cnt_reg[gi] - 3'd1;
            default: out_cnt_reg[gi] <= out_cnt_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg        <= '0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (grant_valid)
        rr_ptr_reg <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
      if (|underflow_vec)
        err_underflow_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_neighbor_req_arbiter.sv
// Directed bench for neighbor_req_arbiter: reset, single write, round robin,
// backpressure, outstanding limit, underflow flag and reset mid-operation.
module tb_neighbor_req_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  neighbor_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(17), .TAG_W(2)) bus ();

  neighbor_req_arbiter #(.NUM_REQ(4), .ADDR_W(17), .TAG_W(2), .MAX_OUT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid = 4'h0;
    bus.req_addr  = '0;
    bus.resp_done = 4'h0;
    bus.wfull     = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic set_addr(input int pe, input logic [16:0] a);
    bus.req_addr[pe*17 +: 17] = a;
  endtask

  task automatic expect_write(input string name, input logic [1:0] tag, input logic [16:0] addr);
    checks++;
    if (bus.wdata_valid !== 1'b1 || bus.wdata_tag !== tag || bus.wdata_addr !== addr) begin
      failures++;
      $display("FAIL %s: got valid=%b tag=%0d addr=%h, want valid=1 tag=%0d addr=%h",
               name, bus.wdata_valid, bus.wdata_tag, bus.wdata_addr, tag, addr);
    end else begin
      $display("txn %s: write tag=%0d addr=%h", name, tag, addr);
    end
  endtask

  task automatic expect_no_write(input string name);
    checks++;
    if (bus.wdata_valid !== 1'b0 || bus.wdata_tag !== 2'd0 || bus.wdata_addr !== 17'd0) begin
      failures++;
      $display("FAIL %s: got valid=%b tag=%0d addr=%h, want no write (0/0/0)",
               name, bus.wdata_valid, bus.wdata_tag, bus.wdata_addr);
    end else begin
      $display("txn %s: no write", name);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    bus.req_valid = 4'hF;
    tick();
    checks++;
    if (bus.req_ready !== 4'h0) begin
      failures++; $display("FAIL reset_ready: got %h want 0", bus.req_ready);
    end
    expect_no_write("reset_wdata");
    checks++;
    if (bus.idle !== 1'b1) begin
      failures++; $display("FAIL reset_idle: got %b want 1", bus.idle);
    end
    checks++;
    if (bus.err_underflow !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b want 0", bus.err_underflow);
    end
    bus.req_valid = 4'h0;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 4'hF) begin
      failures++; $display("FAIL release_ready: got %h want F", bus.req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 4'h1;
    set_addr(0, {2'b00, 10'd0, 5'd5});
    #1;
    expect_no_write("single_no_passthru");
    tick();
    bus.req_valid = 4'h0;
    expect_write("single_write", 2'd0, 17'h00005);
    checks++;
    if (bus.req_ready[0] !== 1'b0) begin
      failures++; $display("FAIL single_ready_held: got %b want 0", bus.req_ready[0]);
    end
    tick();
    expect_no_write("single_once");
    checks++;
    if (bus.idle !== 1'b0 || bus.req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL single_outstanding: got idle=%b ready0=%b want idle=0 ready0=1",
                           bus.idle, bus.req_ready[0]);
    end
    bus.resp_done = 4'h1;
    tick();
    bus.resp_done = 4'h0;
    #1;
    checks++;
    if (bus.idle !== 1'b1 || bus.err_underflow !== 1'b0) begin
      failures++; $display("FAIL single_done: got idle=%b err=%b want idle=1 err=0",
                           bus.idle, bus.err_underflow);
    end
  endtask

  task automatic test_round_robin();
    logic [16:0] addrs [4];
    addrs[0] = 17'h00011;
    addrs[1] = 17'h08122;
    addrs[2] = 17'h10233;
    addrs[3] = 17'h1FFE0;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) set_addr(i, addrs[i] ^ 17'(rep));
      bus.req_valid = 4'hF;
      tick();
      bus.req_valid = 4'h0;
      for (int k = 0; k < 4; k++) begin
        expect_write($sformatf("rr%0d_slot%0d", rep, k), 2'(k), addrs[k] ^ 17'(rep));
        tick();
      end
      expect_no_write($sformatf("rr%0d_after", rep));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.wfull = 1'b1;
    bus.req_valid = 4'h2;
    set_addr(1, {2'b01, 10'd2, 5'd5});
    tick();
    bus.req_valid = 4'h0;
    for (int c = 0; c < 5; c++) begin
      expect_no_write($sformatf("bp_full%0d", c));
      checks++;
      if (bus.req_ready[1] !== 1'b0) begin
        failures++; $display("FAIL bp_ready%0d: got %b want 0", c, bus.req_ready[1]);
      end
      tick();
    end
    bus.wfull = 1'b0;
    #1;
    expect_write("bp_release", 2'd1, 17'h08045);
    tick();
    expect_no_write("bp_single");
  endtask

  task automatic test_max_out();
    do_reset();
    bus.req_valid = 4'h4; set_addr(2, 17'h00A01);
    tick(); bus.req_valid = 4'h0;
    expect_write("mo_first", 2'd2, 17'h00A01);
    tick();
    bus.req_valid = 4'h4; set_addr(2, 17'h00A02);
    tick(); bus.req_valid = 4'h0;
    expect_write("mo_second", 2'd2, 17'h00A02);
    tick();
    bus.req_valid = 4'h4; set_addr(2, 17'h00A03);
    tick(); bus.req_valid = 4'h0;
    expect_no_write("mo_third_blocked");
    tick();
    expect_no_write("mo_third_still");
    bus.resp_done = 4'h4;
    #1;
    expect_no_write("mo_done_cycle");
    tick();
    bus.resp_done = 4'h4;
    expect_write("mo_third", 2'd2, 17'h00A03);
    tick();
    bus.resp_done = 4'h0;
    bus.req_valid = 4'h4; set_addr(2, 17'h00A04);
    tick(); bus.req_valid = 4'h0;
    expect_write("mo_fourth", 2'd2, 17'h00A04);
    tick();
    bus.req_valid = 4'h4; set_addr(2, 17'h00A05);
    tick(); bus.req_valid = 4'h0;
    expect_no_write("mo_fifth_blocked");
    checks++;
    if (bus.err_underflow !== 1'b0) begin
      failures++; $display("FAIL mo_err: got %b want 0", bus.err_underflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.resp_done = 4'h8;
    tick();
    bus.resp_done = 4'h0;
    checks++;
    if (bus.err_underflow !== 1'b1 || bus.idle !== 1'b1) begin
      failures++; $display("FAIL uf_set: got err=%b idle=%b want err=1 idle=1",
                           bus.err_underflow, bus.idle);
    end
    tick();
    tick();
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      failures++; $display("FAIL uf_sticky: got %b want 1", bus.err_underflow);
    end
    bus.req_valid = 4'h8; set_addr(3, 17'h1F00F);
    tick(); bus.req_valid = 4'h0;
    expect_write("uf_count_zero", 2'd3, 17'h1F00F);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 17'(17'h00100 + i));
    bus.req_valid = 4'hF;
    tick();
    bus.req_valid = 4'h0;
    expect_write("mid_slot0", 2'd0, 17'h00100);
    tick();
    expect_write("mid_slot1", 2'd1, 17'h00101);
    reset = 1'b0;
    #1;
    expect_no_write("mid_async");
    checks++;
    if (bus.req_ready !== 4'h0 || bus.idle !== 1'b1) begin
      failures++; $display("FAIL mid_state: got ready=%h idle=%b want ready=0 idle=1",
                           bus.req_ready, bus.idle);
    end
    tick();
    expect_no_write("mid_hold");
    reset = 1'b1;
    #1;
    expect_no_write("mid_dropped");
    checks++;
    if (bus.req_ready !== 4'hF || bus.idle !== 1'b1) begin
      failures++; $display("FAIL mid_release: got ready=%h idle=%b want ready=F idle=1",
                           bus.req_ready, bus.idle);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max_out();
    test_underflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
